fp_mul_scheduler: RTL and testbench

FP_MUL_SCHEDULER -- requirements
Module: fp_mul_scheduler

---
 rtl/fp_mul_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_fp_mul_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_scheduler
// Description : Round-robin scheduler that shares one floating-point
//               multiplier between two requesters. One operation is in flight
//               at a time: IDLE -> WAIT (MUL_LAT cycles) -> RESP -> IDLE.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MUL_LAT     cycles the multiplier operands are held before the result is
//               sampled (legal range 1..15)
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   [1:0]  per-requester operation present
//   req_ready   [1:0]  per-requester accept (one-hot, IDLE only)
//   req_fp_X    [63:0] operand X, [31:0] requester 0, [63:32] requester 1
//   req_fp_Y    [63:0] operand Y, same packing
//   req_r_mode  [5:0]  rounding mode, [2:0] requester 0, [5:3] requester 1
//   mul_fp_X/Y  [31:0] registered operands to the shared multiplier
//   mul_r_mode  [2:0]  registered rounding mode to the shared multiplier
//   mul_fp_Z    [31:0] multiplier result
//   mul_ovrf/udrf      multiplier overflow / underflow flags
//   rsp_valid   [1:0]  per-requester response available (one-hot)
//   rsp_ready   [1:0]  per-requester response consumed
//   rsp_fp_Z    [31:0] captured result, shared by both response channels
//   rsp_ovrf/udrf      captured flags
//   busy               FSM not in IDLE
// ============================================================================
module fp_mul_scheduler #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_fp_X,
  input  logic [63:0] req_fp_Y,
  input  logic [5:0]  req_r_mode,
  output logic [31:0] mul_fp_X,
  output logic [31:0] mul_fp_Y,
  output logic [2:0]  mul_r_mode,
  input  logic [31:0] mul_fp_Z,
  input  logic        mul_ovrf,
  input  logic        mul_udrf,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_fp_Z,
  output logic        rsp_ovrf,
  output logic        rsp_udrf,
  output logic        busy
);

  // Four bits cover the largest load value MUL_LAT-1 = 14.
  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [2:0]      RM_RNE   = 3'b000;
  localparam logic [2:0]      RM_MAX   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;        // preferred requester when both are valid
  logic             owner;      // requester of the in-flight operation
  logic [CNT_W-1:0] cnt;

  logic             grant_any;
  logic             grant_idx;
  logic             accept;
  logic             rsp_done;
  logic [31:0]      sel_x;
  logic [31:0]      sel_y;
  logic [2:0]       sel_mode;
  logic [2:0]       mode_clean;

  // --------------------------------------------------------------------------
  // Arbitration: a lone valid requester always wins; on contention the
  // pointer decides.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr;
    case (req_valid)
      2'b01: begin
        grant_any = 1'b1;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant_any = 1'b1;
        grant_idx = 1'b1;
      end
      2'b11: begin
        grant_any = 1'b1;
        grant_idx = ptr;
      end
      default: begin
        grant_any = 1'b0;
        grant_idx = ptr;
      end
    endcase
  end

  // req_ready is combinational from state and req_valid; gating with rst_n
  // keeps it low while reset is held even though IDLE is the reset state.
  assign req_ready = (rst_n && (state == ST_IDLE) && grant_any)
                     ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

  assign accept    = |(req_valid & req_ready);

  // Operand selection for the granted requester.
  assign sel_x     = grant_idx ? req_fp_X[63:32]  : req_fp_X[31:0];
  assign sel_y     = grant_idx ? req_fp_Y[63:32]  : req_fp_Y[31:0];
  assign sel_mode  = grant_idx ? req_r_mode[5:3]  : req_r_mode[2:0];

  // Encodings above the last defined mode fall back to round-to-nearest-even.
  assign mode_clean = (sel_mode > RM_MAX) ? RM_RNE : sel_mode;

  // Only the owner's rsp_ready can complete the response.
  assign rsp_done  = (state == ST_RESP) && rsp_ready[owner];

  assign rsp_valid = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)       state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == '0)    state_nxt = ST_RESP;
      ST_RESP: if (rsp_done)     state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Request side: operands, owner, pointer and latency counter.
  // The cnt==0 cycle is the last WAIT cycle, so capture lands on edge
  // accept+MUL_LAT; with MUL_LAT=1 the counter loads 0 and WAIT is one cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_fp_X   <= '0;
      mul_fp_Y   <= '0;
      mul_r_mode <= '0;
      owner      <= 1'b0;
      ptr        <= 1'b0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        mul_fp_X   <= sel_x;
        mul_fp_Y   <= sel_y;
        mul_r_mode <= mode_clean;
        owner      <= grant_idx;
        ptr        <= ~grant_idx;
        cnt        <= CNT_LOAD;
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response side: result and flags are captured once and held through RESP.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_fp_Z <= '0;
      rsp_ovrf <= 1'b0;
      rsp_udrf <= 1'b0;
    end else if ((state == ST_WAIT) && (cnt == '0)) begin
      rsp_fp_Z <= mul_fp_Z;
      rsp_ovrf <= mul_ovrf;
      rsp_udrf <= mul_udrf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_scheduler
// Description : Self-checking bench for fp_mul_scheduler. Instance dut uses
//               MUL_LAT=2, instance dut_b uses MUL_LAT=1. The bench plays the
//               multiplier: it presents the expected result only in the cycle
//               the scheduler should sample it, and its complement otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_scheduler;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // MUL_LAT = 2 instance
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_fp_X, req_fp_Y;
  logic [5:0]  req_r_mode;
  logic [31:0] mul_fp_X, mul_fp_Y, mul_fp_Z, rsp_fp_Z;
  logic [2:0]  mul_r_mode;
  logic        mul_ovrf, mul_udrf, rsp_ovrf, rsp_udrf, busy;

  // MUL_LAT = 1 instance
  logic [1:0]  req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
  logic [63:0] req_fp_X_b, req_fp_Y_b;
  logic [5:0]  req_r_mode_b;
  logic [31:0] mul_fp_X_b, mul_fp_Y_b, mul_fp_Z_b, rsp_fp_Z_b;
  logic [2:0]  mul_r_mode_b;
  logic        mul_ovrf_b, mul_udrf_b, rsp_ovrf_b, rsp_udrf_b, busy_b;

  fp_mul_scheduler #(.MUL_LAT(LAT_A)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fp_X(req_fp_X), .req_fp_Y(req_fp_Y), .req_r_mode(req_r_mode),
    .mul_fp_X(mul_fp_X), .mul_fp_Y(mul_fp_Y), .mul_r_mode(mul_r_mode),
    .mul_fp_Z(mul_fp_Z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_fp_Z(rsp_fp_Z), .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf),
    .busy(busy)
  );

  fp_mul_scheduler #(.MUL_LAT(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_fp_X(req_fp_X_b), .req_fp_Y(req_fp_Y_b), .req_r_mode(req_r_mode_b),
    .mul_fp_X(mul_fp_X_b), .mul_fp_Y(mul_fp_Y_b), .mul_r_mode(mul_r_mode_b),
    .mul_fp_Z(mul_fp_Z_b), .mul_ovrf(mul_ovrf_b), .mul_udrf(mul_udrf_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_fp_Z(rsp_fp_Z_b), .rsp_ovrf(rsp_ovrf_b), .rsp_udrf(rsp_udrf_b),
    .busy(busy_b)
  );

  typedef struct {
    int          req;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  mode;
    logic [2:0]  exp_mode;
    logic [31:0] z;
    logic        ov;
    logic        ud;
    int          hold;      // extra RESP cycles with owner's rsp_ready low
  } vec_t;

  typedef struct {
    int          req;
    logic [31:0] z;
    logic        ov;
    logic        ud;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one operation through dut; entered and left at 1 time unit after a
  // rising edge.
  task automatic run_op(input vec_t v);
    logic [1:0] onehot;
    logic [1:0] eoh;
    int         n;
    exp_t       e;
    onehot     = (v.req == 1) ? 2'b10 : 2'b01;
    req_valid  = onehot;
    req_fp_X   = (v.req == 1) ? {v.x, ~v.x} : {~v.x, v.x};
    req_fp_Y   = (v.req == 1) ? {v.y, ~v.y} : {~v.y, v.y};
    req_r_mode = (v.req == 1) ? {v.mode, ~v.mode} : {~v.mode, v.mode};
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("grant", req_ready, onehot);
    e.req = v.req; e.z = v.z; e.ov = v.ov; e.ud = v.ud;
    sb.push_back(e);
    @(posedge clk); #1;                  // accept edge passed
    req_valid  = 2'b00;
    req_fp_X   = ~req_fp_X;              // operands must not follow inputs
    req_fp_Y   = ~req_fp_Y;
    req_r_mode = ~req_r_mode;
    check("mul_fp_X", mul_fp_X, v.x);
    check("mul_fp_Y", mul_fp_Y, v.y);
    check("mul_r_mode", mul_r_mode, v.exp_mode);
    check("busy_wait", busy, 1'b1);
    check("req_ready_wait", req_ready, 2'b00);
    for (int k = 0; k < LAT_A - 1; k++) begin
      check("rsp_early", rsp_valid, 2'b00);
      @(posedge clk); #1;
    end
    mul_fp_Z = v.z; mul_ovrf = v.ov; mul_udrf = v.ud;
    check("rsp_early", rsp_valid, 2'b00);
    @(posedge clk); #1;                  // capture edge passed
    mul_fp_Z = ~v.z; mul_ovrf = ~v.ov; mul_udrf = ~v.ud;
    req_valid = 2'b11;
    e   = sb.pop_front();
    eoh = (e.req == 1) ? 2'b10 : 2'b01;
    check("rsp_valid", rsp_valid, eoh);
    check("rsp_fp_Z", rsp_fp_Z, e.z);
    check("rsp_ovrf", rsp_ovrf, e.ov);
    check("rsp_udrf", rsp_udrf, e.ud);
    rsp_ready = ~eoh;                    // non-owner ready must be ignored
    for (int k = 0; k <= v.hold; k++) begin
      @(posedge clk); #1;
      check("rsp_hold_valid", rsp_valid, eoh);
      check("rsp_hold_Z", rsp_fp_Z, e.z);
      check("rsp_hold_ready", req_ready, 2'b00);
      check("rsp_hold_busy", busy, 1'b1);
    end
    rsp_ready = eoh;
    #1;
    check("req_ready_handshake", req_ready, 2'b00);
    @(posedge clk); #1;                  // handshake edge passed
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    check("rsp_cleared", rsp_valid, 2'b00);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int grants [$];
    int times  [$];

    vecs[0] = '{0, 32'h40400000, 32'h40400000, 3'b001, 3'b001, 32'h41100000, 1'b0, 1'b0, 0};
    vecs[1] = '{1, 32'h3f800000, 32'hc0000000, 3'b111, 3'b000, 32'hc0000000, 1'b0, 1'b0, 0};
    vecs[2] = '{1, 32'h7f000000, 32'h7f000000, 3'b100, 3'b100, 32'h7f800000, 1'b1, 1'b0, 0};
    vecs[3] = '{0, 32'h00800000, 32'h00800000, 3'b101, 3'b000, 32'h00000000, 1'b0, 1'b1, 5};
    vecs[4] = '{0, 32'h3fc00000, 32'h40000000, 3'b110, 3'b000, 32'h40400000, 1'b0, 1'b0, 0};
    vecs[5] = '{1, 32'hbf800000, 32'h3f800000, 3'b011, 3'b011, 32'hbf800000, 1'b0, 1'b0, 2};

    rst_n = 1'b0;
    req_valid = 2'b11; req_fp_X = '0; req_fp_Y = '0; req_r_mode = '0;
    mul_fp_Z = 32'hdeadbeef; mul_ovrf = 1'b0; mul_udrf = 1'b0; rsp_ready = 2'b00;
    req_valid_b = 2'b00; req_fp_X_b = '0; req_fp_Y_b = '0; req_r_mode_b = '0;
    mul_fp_Z_b = 32'hdeadbeef; mul_ovrf_b = 1'b0; mul_udrf_b = 1'b0; rsp_ready_b = 2'b00;
    #2;
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_mul_X", mul_fp_X, 32'h0);
    check("reset_rsp_Z", rsp_fp_Z, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 2'b00;

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset pulse during WAIT, after a grant to requester 0 moved the pointer.
    req_valid = 2'b01;
    req_fp_X = {32'h0, 32'h12345678}; req_fp_Y = {32'h0, 32'h9abcdef0};
    req_r_mode = 6'b000_011;
    #1;
    check("rst_pre_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b11;
    check("rst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_mul_X", mul_fp_X, 32'h0);
    check("rst_mul_Y", mul_fp_Y, 32'h0);
    check("rst_mul_mode", mul_r_mode, 3'b000);
    check("rst_rsp_Z", rsp_fp_Z, 32'h0);
    check("rst_rsp_flags", {rsp_ovrf, rsp_udrf}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 2'b00;
    mul_fp_Z = 32'h55aa55aa; mul_ovrf = 1'b1; mul_udrf = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", rsp_valid, 2'b00);
      check("post_rst_idle", busy, 1'b0);
    end

    // Both requesters continuously valid: alternating grants, fixed spacing.
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 30 && grants.size() < 4; c++) begin
      #1;
      if (req_ready == 2'b01) begin grants.push_back(0); times.push_back(c); end
      else if (req_ready == 2'b10) begin grants.push_back(1); times.push_back(c); end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    check("rr_count", grants.size(), 4);
    for (int k = 0; k < grants.size(); k++) begin
      check("rr_grant", grants[k], k % 2);
      if (k == 0) check("rr_first_time", times[k], 0);
      else        check("rr_spacing", times[k] - times[k-1], LAT_A + 2);
    end
    repeat (6) @(posedge clk);
    #1;
    rsp_ready = 2'b00;
    check("rr_drained", busy, 1'b0);

    // MUL_LAT = 1 with overflow.
    req_valid_b = 2'b01;
    req_fp_X_b = {32'h0, 32'h7f7fffff}; req_fp_Y_b = {32'h0, 32'h7f7fffff};
    req_r_mode_b = 6'b000_010;
    #1;
    check("b_grant", req_ready_b, 2'b01);
    @(posedge clk); #1;
    req_valid_b = 2'b00;
    check("b_wait_no_rsp", rsp_valid_b, 2'b00);
    check("b_busy", busy_b, 1'b1);
    mul_fp_Z_b = 32'h7f800000; mul_ovrf_b = 1'b1; mul_udrf_b = 1'b0;
    @(posedge clk); #1;
    mul_fp_Z_b = 32'h0; mul_ovrf_b = 1'b0; mul_udrf_b = 1'b1;
    check("b_rsp_valid", rsp_valid_b, 2'b01);
    check("b_rsp_ovrf", rsp_ovrf_b, 1'b1);
    check("b_rsp_udrf", rsp_udrf_b, 1'b0);
    check("b_rsp_Z", rsp_fp_Z_b, 32'h7f800000);
    rsp_ready_b = 2'b01;
    @(posedge clk); #1;
    rsp_ready_b = 2'b00;
    check("b_rsp_cleared", rsp_valid_b, 2'b00);
    check("b_idle", busy_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
